// File: rtl/classify_ctrl.sv
// Sequencer for the 10-way argmax stage: collects logits, fires the argmax unit,
// waits for its finish under a watchdog and presents the class on a valid/ready port.
module classify_ctrl #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          am_enable,
  output logic [NUM_CLASSES*DATA_W-1:0] am_din,
  input  logic [IDX_W-1:0]              am_dout,
  input  logic                          am_finish,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_class,
  output logic                          busy,
  output logic                          err,
  output logic [15:0]                   img_count
);

  localparam int unsigned BUS_W = NUM_CLASSES * DATA_W;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_FIRE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BUS_W-1:0]   buf_q, buf_d;
  logic               am_enable_q, am_enable_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_class_q, out_class_d;
  logic               err_q, err_d;
  logic [15:0]        img_count_q, img_count_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  int unsigned        slot_lo;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    am_enable_d = 1'b0;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    err_d       = err_q;
    img_count_d = img_count_q;
    wait_cnt_d  = wait_cnt_q;
    // Class 0 occupies the MSB slot of the packed bus.
    slot_lo     = (NUM_CLASSES - 1 - 32'(idx_q)) * DATA_W;

    case (state_q)
      S_COLLECT: begin
        if (in_valid && in_ready_q) begin
          buf_d[slot_lo +: DATA_W] = in_data;
          if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
            idx_d       = '0;
            state_d     = S_FIRE;
            am_enable_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_FIRE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (am_finish) begin
          out_class_d = am_dout;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          out_class_d = {IDX_W{1'b1}};
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          img_count_d = img_count_q + 16'd1;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    in_ready_d = (state_d == S_COLLECT);
    busy_d     = !((state_d == S_COLLECT) && (idx_d == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      idx_q       <= '0;
      buf_q       <= '0;
      am_enable_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      err_q       <= 1'b0;
      img_count_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      am_enable_q <= am_enable_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      err_q       <= err_d;
      img_count_q <= img_count_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign am_enable = am_enable_q;
  assign am_din    = buf_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign img_count = img_count_q;

endmodule

// File: tb/tb_classify_ctrl.sv
// Bench for classify_ctrl: behavioural argmax unit plus a queue of expected classes.
module tb_classify_ctrl;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned DATA_W      = 18;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned BUS_W       = NUM_CLASSES * DATA_W;

  typedef logic signed [DATA_W-1:0] frame_t [NUM_CLASSES];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic               am_enable;
  logic [BUS_W-1:0]   am_din;
  logic [IDX_W-1:0]   am_dout = '0;
  logic               am_finish = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [IDX_W-1:0]   out_class;
  logic               busy;
  logic               err;
  logic [15:0]        img_count;

  bit                 stub_en = 1'b1;
  int                 en_cnt = 0;
  int                 pass_cnt = 0;
  int                 chk_cnt = 0;
  logic [IDX_W-1:0]   exp_q [$];

  classify_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .am_enable(am_enable), .am_din(am_din), .am_dout(am_dout), .am_finish(am_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .busy(busy),
    .err(err), .img_count(img_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IDX_W-1:0] ref_argmax(input frame_t f);
    int best = 0;
    for (int i = 1; i < int'(NUM_CLASSES); i++)
      if (f[i] > f[best]) best = i;
    return IDX_W'(best);
  endfunction

  function automatic logic [IDX_W-1:0] bus_argmax(input logic [BUS_W-1:0] b);
    frame_t f;
    for (int i = 0; i < int'(NUM_CLASSES); i++)
      f[i] = b[(int'(NUM_CLASSES) - 1 - i) * int'(DATA_W) +: DATA_W];
    return ref_argmax(f);
  endfunction

  // Argmax unit: finish one cycle after the enable edge (suppressible for the watchdog test).
  always @(posedge clk) begin
    am_finish <= am_enable && stub_en;
    am_dout   <= bus_argmax(am_din);
    if (am_enable === 1'b1) en_cnt <= en_cnt + 1;
  end

  task automatic send_frame(input frame_t f, input bit gapped, input int nbeats, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      int guard = 0;
      if (gapped) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 18'h2AAAA;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
      while (!in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) ok = 1'b0;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit to);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    to = !out_valid;
  endtask

  task automatic pop_exp(output logic [IDX_W-1:0] e, output bit ok);
    ok = (exp_q.size() > 0);
    e  = ok ? exp_q.pop_front() : 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    chk_cnt++; if (img_count !== 16'd0) $display("FAIL reset_img_count got %0d want 0", img_count); else pass_cnt++;
    chk_cnt++; if (am_enable !== 1'b0) $display("FAIL reset_am_enable got %b want 0", am_enable); else pass_cnt++;
    chk_cnt++; if (am_din !== '0) $display("FAIL reset_am_din got %h want 0", am_din); else pass_cnt++;
    chk_cnt++; if (out_class !== 4'h0) $display("FAIL reset_out_class got %h want 0", out_class); else pass_cnt++;
  endtask

  task automatic test_single();
    frame_t f = '{18'sd5, -18'sd3, 18'sd100, 18'sd7, 18'sd100, 18'sd0, -18'sd1, 18'sd2, 18'sd3, 18'sd4};
    int n, en0;
    bit ok, to, pok;
    logic [IDX_W-1:0] e;
    logic [15:0] img0 = img_count;
    en0 = en_cnt;
    out_ready = 1'b1;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b0, 10, ok);
    chk_cnt++; if (!ok) $display("FAIL single_accept got stalled want accepted"); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_fire got %b want 1", busy); else pass_cnt++;
    wait_valid(n, to);
    chk_cnt++; if (to || n - 1 != 2) $display("FAIL single_latency got %0d want 2", n - 1); else pass_cnt++;
    pop_exp(e, pok);
    chk_cnt++; if (!pok || out_class !== e || e !== 4'd2) $display("FAIL single_class got %0d want 2", out_class); else pass_cnt++;
    chk_cnt++; if (am_din[179:162] !== 18'd5) $display("FAIL single_am_din_msb got %0d want 5", am_din[179:162]); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drop_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (img_count !== img0 + 16'd1) $display("FAIL single_img_count got %0d want %0d", img_count, img0 + 16'd1); else pass_cnt++;
    chk_cnt++; if (en_cnt - en0 != 1) $display("FAIL single_enable_pulses got %0d want 1", en_cnt - en0); else pass_cnt++;
  endtask

  task automatic test_negative();
    frame_t f;
    int n, en0;
    bit ok, to, pok;
    logic [IDX_W-1:0] e;
    for (int i = 0; i < int'(NUM_CLASSES); i++) f[i] = DATA_W'(i - 10);
    en0 = en_cnt;
    exp_q.push_back(4'd9);
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e) $display("FAIL negative_class got %0d want 9", out_class); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (en_cnt - en0 != 1) $display("FAIL negative_enable_pulses got %0d want 1", en_cnt - en0); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    frame_t f = '{-18'sd7, 18'sd20, 18'sd3, 18'sd21, 18'sd0, 18'sd21, 18'sd1, 18'sd2, 18'sd3, 18'sd4};
    int n;
    bit ok, to, pok, stable = 1'b1;
    logic [IDX_W-1:0] e;
    logic [15:0] img0 = img_count;
    out_ready = 1'b0;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e) $display("FAIL bp_class got %0d want %0d", out_class, e); else pass_cnt++;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_class !== e || in_ready !== 1'b0 || img_count !== img0) stable = 1'b0;
    end
    chk_cnt++; if (!stable) $display("FAIL bp_hold_stable got changed want held"); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (img_count !== img0 + 16'd1) $display("FAIL bp_img_count got %0d want %0d", img_count, img0 + 16'd1); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_gapped();
    frame_t f = '{18'sd11, 18'sd12, -18'sd13, 18'sd14, 18'sd15, 18'sd16, 18'sd17, 18'sd99, 18'sd18, 18'sd19};
    int n;
    bit ok, to, pok;
    logic [IDX_W-1:0] e;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b1, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e) $display("FAIL gapped_class got %0d want %0d", out_class, e); else pass_cnt++;
    chk_cnt++; if (am_din[161:144] !== 18'd12 || am_din[17:0] !== 18'd19) $display("FAIL gapped_slots got %h want slot1=12 slot9=19", am_din); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    frame_t f = '{18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd60, 18'sd7, 18'sd8, 18'sd9, 18'sd10};
    int n;
    bit ok, to, pok;
    logic [IDX_W-1:0] e;
    stub_en = 1'b0;
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    chk_cnt++; if (to || n - 1 != 9) $display("FAIL timeout_latency got %0d want 9", n - 1); else pass_cnt++;
    chk_cnt++; if (out_class !== 4'hF) $display("FAIL timeout_class got %h want f", out_class); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1) $display("FAIL timeout_err got %b want 1", err); else pass_cnt++;
    @(negedge clk);
    stub_en = 1'b1;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e || e !== 4'd5) $display("FAIL after_timeout_class got %0d want 5", out_class); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    frame_t f = '{18'sd1, 18'sd2, 18'sd3, -18'sd4, 18'sd50, 18'sd6, 18'sd50, 18'sd8, 18'sd9, 18'sd10};
    int n;
    bit ok, to, pok, quiet = 1'b1;
    logic [IDX_W-1:0] e;
    send_frame(f, 1'b0, 6, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_idle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); else pass_cnt++;
    chk_cnt++; if (am_din !== '0 || err !== 1'b0) $display("FAIL midrst_cleared got din=%h err=%b want 0", am_din, err); else pass_cnt++;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || am_enable !== 1'b0) quiet = 1'b0;
    end
    chk_cnt++; if (!quiet) $display("FAIL midrst_no_result got activity want none"); else pass_cnt++;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e || e !== 4'd4) $display("FAIL midrst_class got %0d want 4", out_class); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    frame_t f = '{18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd1};
    int n;
    bit ok, to, pok;
    logic [IDX_W-1:0] e;
    @(negedge clk);
    force dut.img_count_q = 16'hFFFF;
    #1 release dut.img_count_q;
    @(negedge clk);
    chk_cnt++; if (img_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", img_count); else pass_cnt++;
    exp_q.push_back(ref_argmax(f));
    send_frame(f, 1'b0, 10, ok);
    wait_valid(n, to);
    pop_exp(e, pok);
    chk_cnt++; if (to || !pok || out_class !== e) $display("FAIL wrap_class got %0d want %0d", out_class, e); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (img_count !== 16'h0000) $display("FAIL wrap_img_count got %h want 0000", img_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_backpressure();
    test_gapped();
    test_timeout();
    test_reset_mid_frame();
    test_wrap();
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
